// File: rtl/ahb_wrr_arbiter_pkg.sv
// Shared AHB arbiter types: burst encoding, arbiter FSM states and the
// beat-limit lookup used to find the final beat of a transaction.
package ahb_wrr_arbiter_pkg;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Undefined-length INCR is arbitrated per beat, like SINGLE.
   function automatic logic [4:0] beat_limit(input hburst_type burst);
      logic [4:0] limit;
      case (burst)
         WRAP4, INCR4:   limit = 5'd4;
         WRAP8, INCR8:   limit = 5'd8;
         WRAP16, INCR16: limit = 5'd16;
         default:        limit = 5'd1;
      endcase
      return limit;
   endfunction

endpackage

// File: rtl/ahb_wrr_arbiter_if.sv
// Bus bundle between the requesting masters and the arbiter.
//   master modport: drives hreq/hburst/hwait/hweight, sees the grant side.
//   slave modport : arbiter side, consumes requests, drives hgrant/hsel/hmaster/hlast.
interface ahb_wrr_arbiter_if
   import ahb_wrr_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = 4,
   parameter int WEIGHT_BIT = 4
);
   localparam int IW = $clog2(MASTER_NUM);

   logic [MASTER_NUM-1:0]                 hreq;
   hburst_type                            hburst;
   logic                                  hwait;
   logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0] hweight;
   logic [MASTER_NUM-1:0]                 hgrant;
   logic                                  hsel;
   logic [IW-1:0]                         hmaster;
   logic                                  hlast;

   modport master (
      output hreq, hburst, hwait, hweight,
      input  hgrant, hsel, hmaster, hlast
   );

   modport slave (
      input  hreq, hburst, hwait, hweight,
      output hgrant, hsel, hmaster, hlast
   );

endinterface

// File: rtl/ahb_wrr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of mask found scanning
// upward from start, wrapping past N-1 to 0. Result is one-hot or zero.
//   mask  : candidate vector
//   start : index scanned first
//   pick  : one-hot winner
module ahb_wrr_arbiter_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         mask,
   input  logic [$clog2(N)-1:0] start,
   output logic [N-1:0]         pick
);
   localparam int IW = $clog2(N);

   logic [IW:0]   sum;
   logic [IW:0]   wrapped;
   logic          found;

   always_comb begin
      pick    = '0;
      found   = 1'b0;
      sum     = '0;
      wrapped = '0;
      for (int i = 0; i < N; i++) begin
         sum     = {1'b0, start} + (IW+1)'(i);
         wrapped = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
         if (!found && mask[wrapped[IW-1:0]]) begin
            pick[wrapped[IW-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin AHB arbiter. Each master may win up to its weight
// in transactions per round; once every requester is out of credit all
// credits reload and a new round starts.
//   hclk, hreset : clock, synchronous active-high reset
//   bus          : request/burst/wait/weight in, grant/select/owner/last out
//
// state | meaning
// IDLE  | no owner, waiting for any request
// BURST | grant_q owns the slave until the final beat is accepted
module ahb_wrr_arbiter
   import ahb_wrr_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = 4,
   parameter int WEIGHT_BIT = 4
) (
   input  logic             hclk,
   input  logic             hreset,
   ahb_wrr_arbiter_if.slave bus
);
   localparam int IW = $clog2(MASTER_NUM);

   arb_state_e            state_q, state_d;
   logic [MASTER_NUM-1:0] grant_q, grant_d;
   logic [4:0]            beat_q, beat_d;
   logic [IW-1:0]         last_q, last_d;
   logic [WEIGHT_BIT-1:0] credit_q [MASTER_NUM];
   logic [WEIGHT_BIT-1:0] credit_d [MASTER_NUM];

   logic [MASTER_NUM-1:0] eligible;
   logic [MASTER_NUM-1:0] search_mask;
   logic [MASTER_NUM-1:0] pick;
   logic [IW-1:0]         start_ptr;
   logic [IW-1:0]         pick_idx;
   logic [IW-1:0]         owner_idx;
   logic                  reload;
   logic                  last_beat;
   logic                  arb;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < MASTER_NUM; i++)
         eligible[i] = bus.hreq[i] && (credit_q[i] != '0);
   end

   // Nobody with credit is asking: start a fresh round over raw requests.
   assign reload      = (eligible == '0);
   assign search_mask = reload ? bus.hreq : eligible;
   assign start_ptr   = (last_q == IW'(MASTER_NUM-1)) ? '0 : last_q + IW'(1);

   ahb_wrr_arbiter_rr_pick #(.N(MASTER_NUM)) u_rr_pick (
      .mask  (search_mask),
      .start (start_ptr),
      .pick  (pick)
   );

   always_comb begin
      pick_idx  = '0;
      owner_idx = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (pick[i])    pick_idx  = pick_idx  | IW'(i);
         if (grant_q[i]) owner_idx = owner_idx | IW'(i);
      end
   end

   assign last_beat = (state_q == BURST) && !bus.hwait &&
                      (beat_q == beat_limit(bus.hburst) - 5'd1);
   // Re-arbitrating on the final beat lets the next owner start with no gap.
   assign arb       = (bus.hreq != '0) && ((state_q == IDLE) || last_beat);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      beat_d   = beat_q;
      last_d   = last_q;
      credit_d = credit_q;
      if (arb) begin
         state_d = BURST;
         grant_d = pick;
         beat_d  = '0;
         last_d  = pick_idx;
         for (int i = 0; i < MASTER_NUM; i++) begin
            if (reload)
               credit_d[i] = (bus.hweight[i] == '0) ? WEIGHT_BIT'(1) : bus.hweight[i];
            if (pick[i])
               credit_d[i] = credit_d[i] - WEIGHT_BIT'(1);
         end
      end else if (last_beat) begin
         state_d = IDLE;
         grant_d = '0;
         beat_d  = '0;
      end else if ((state_q == BURST) && !bus.hwait) begin
         beat_d = beat_q + 5'd1;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= IDLE;
         grant_q <= '0;
         beat_q  <= '0;
         last_q  <= IW'(MASTER_NUM-1);
         for (int i = 0; i < MASTER_NUM; i++)
            credit_q[i] <= bus.hweight[i];
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         beat_q   <= beat_d;
         last_q   <= last_d;
         credit_q <= credit_d;
      end
   end

   assign bus.hgrant  = grant_q & {MASTER_NUM{~bus.hwait}};
   assign bus.hsel    = |grant_q;
   assign bus.hmaster = owner_idx;
   assign bus.hlast   = last_beat;

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
module tb_ahb_wrr_arbiter;
   import ahb_wrr_arbiter_pkg::*;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic       sel;
      logic [1:0] mst;
      logic       last;
   } exp_t;

   logic hclk;
   logic hreset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t cur;

   ahb_wrr_arbiter_if #(.MASTER_NUM(4), .WEIGHT_BIT(4)) bus ();

   ahb_wrr_arbiter #(.MASTER_NUM(4), .WEIGHT_BIT(4)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus.slave)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Outputs are sampled mid-cycle, against the entry pushed for that cycle.
   always @(negedge hclk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         checks += 4;
         assert (bus.hgrant === cur.grant) else begin
            errors++;
            $error("FAIL %s hgrant observed=%b expected=%b", cur.tag, bus.hgrant, cur.grant);
         end
         assert (bus.hsel === cur.sel) else begin
            errors++;
            $error("FAIL %s hsel observed=%b expected=%b", cur.tag, bus.hsel, cur.sel);
         end
         assert (bus.hmaster === cur.mst) else begin
            errors++;
            $error("FAIL %s hmaster observed=%0d expected=%0d", cur.tag, bus.hmaster, cur.mst);
         end
         assert (bus.hlast === cur.last) else begin
            errors++;
            $error("FAIL %s hlast observed=%b expected=%b", cur.tag, bus.hlast, cur.last);
         end
         checks++;
         assert ($onehot0(bus.hgrant)) else begin
            errors++;
            $error("FAIL %s onehot hgrant observed=%b expected=onehot0", cur.tag, bus.hgrant);
         end
      end
   end

   task automatic cyc(input string tag, input logic [3:0] g, input logic s,
                      input logic [1:0] m, input logic l);
      exp_t e;
      e.tag   = tag;
      e.grant = g;
      e.sel   = s;
      e.mst   = m;
      e.last  = l;
      sb.push_back(e);
      @(posedge hclk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0][3:0] w);
      bus.hweight = w;
      bus.hreq    = 4'b0000;
      bus.hwait   = 1'b0;
      bus.hburst  = SINGLE;
      hreset      = 1'b1;
      @(posedge hclk);
      #1;
      cyc("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      hreset = 1'b0;
   endtask

   initial begin
      hreset      = 1'b1;
      bus.hreq    = 4'b0000;
      bus.hwait   = 1'b0;
      bus.hburst  = SINGLE;
      bus.hweight = {4'd1, 4'd1, 4'd1, 4'd1};

      // single request, single beat, back to idle
      do_reset({4'd1, 4'd1, 4'd1, 4'd1});
      bus.hreq = 4'b0001;
      cyc("single_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      bus.hreq = 4'b0000;
      cyc("single_grant", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("single_back_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

      // all request, equal weights: plain rotation then reload
      do_reset({4'd1, 4'd1, 4'd1, 4'd1});
      bus.hreq = 4'b1111;
      cyc("rr_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      cyc("rr_m0", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("rr_m1", 4'b0010, 1'b1, 2'd1, 1'b1);
      cyc("rr_m2", 4'b0100, 1'b1, 2'd2, 1'b1);
      cyc("rr_m3", 4'b1000, 1'b1, 2'd3, 1'b1);
      cyc("rr_m0_reload", 4'b0001, 1'b1, 2'd0, 1'b1);

      // master0 weight 3 vs master1 weight 1
      do_reset({4'd1, 4'd1, 4'd1, 4'd3});
      bus.hreq = 4'b0011;
      cyc("wrr_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      cyc("wrr_g1_m0", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("wrr_g2_m1", 4'b0010, 1'b1, 2'd1, 1'b1);
      cyc("wrr_g3_m0", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("wrr_g4_m0", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("wrr_g5_m1", 4'b0010, 1'b1, 2'd1, 1'b1);
      cyc("wrr_g6_m0", 4'b0001, 1'b1, 2'd0, 1'b1);

      // zero weights behave as weight 1
      do_reset({4'd0, 4'd0, 4'd0, 4'd0});
      bus.hreq = 4'b0011;
      cyc("w0_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      cyc("w0_m0", 4'b0001, 1'b1, 2'd0, 1'b1);
      cyc("w0_m1", 4'b0010, 1'b1, 2'd1, 1'b1);
      cyc("w0_m0_again", 4'b0001, 1'b1, 2'd0, 1'b1);

      // INCR4 by master2 with two wait cycles on the second beat
      do_reset({4'd1, 4'd1, 4'd1, 4'd1});
      bus.hburst = INCR4;
      bus.hreq   = 4'b0100;
      cyc("wait_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      bus.hreq = 4'b0000;
      cyc("wait_beat1", 4'b0100, 1'b1, 2'd2, 1'b0);
      bus.hwait = 1'b1;
      cyc("wait_hold1", 4'b0000, 1'b1, 2'd2, 1'b0);
      cyc("wait_hold2", 4'b0000, 1'b1, 2'd2, 1'b0);
      bus.hwait = 1'b0;
      cyc("wait_beat2", 4'b0100, 1'b1, 2'd2, 1'b0);
      cyc("wait_beat3", 4'b0100, 1'b1, 2'd2, 1'b0);
      cyc("wait_beat4_last", 4'b0100, 1'b1, 2'd2, 1'b1);
      cyc("wait_after", 4'b0000, 1'b0, 2'd0, 1'b0);

      // reset during the third beat of an INCR8 by master1
      do_reset({4'd1, 4'd1, 4'd1, 4'd1});
      bus.hburst = INCR8;
      bus.hreq   = 4'b0010;
      cyc("abort_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      bus.hreq = 4'b0000;
      cyc("abort_beat1", 4'b0010, 1'b1, 2'd1, 1'b0);
      cyc("abort_beat2", 4'b0010, 1'b1, 2'd1, 1'b0);
      hreset = 1'b1;
      cyc("abort_beat3", 4'b0010, 1'b1, 2'd1, 1'b0);
      hreset   = 1'b0;
      bus.hreq = 4'b0011;
      cyc("abort_cleared", 4'b0000, 1'b0, 2'd0, 1'b0);
      bus.hreq = 4'b0000;
      cyc("abort_m0_wins", 4'b0001, 1'b1, 2'd0, 1'b0);

      // owner drops request mid-WRAP4 while master2 waits
      do_reset({4'd1, 4'd1, 4'd1, 4'd1});
      bus.hburst = WRAP4;
      bus.hreq   = 4'b0001;
      cyc("drop_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
      cyc("drop_beat1", 4'b0001, 1'b1, 2'd0, 1'b0);
      bus.hreq = 4'b0100;
      cyc("drop_beat2", 4'b0001, 1'b1, 2'd0, 1'b0);
      cyc("drop_beat3", 4'b0001, 1'b1, 2'd0, 1'b0);
      cyc("drop_beat4_last", 4'b0001, 1'b1, 2'd0, 1'b1);
      bus.hreq = 4'b0000;
      cyc("drop_m2_granted", 4'b0100, 1'b1, 2'd2, 1'b0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
